// File: rtl/key_search_pkg.sv
// Shared types and constants for the key search controller.
// Optional statistics counters are enabled with the KEY_SEARCH_STATS_EN macro.
package key_search_pkg;

  localparam int W_DEF  = 16;  // default key width
  localparam int N_DEF  = 8;   // default table depth
  localparam int STAT_W = 16;  // hit/miss counter width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/key_search_if.sv
// Search request/result handshake bundle between a client and key_search_ctrl.
interface key_search_if import key_search_pkg::*; #(
  parameter int W = W_DEF,
  parameter int N = N_DEF
);
  localparam int IW = $clog2(N);

  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_key;
  logic          res_valid;
  logic          res_ready;
  logic          res_hit;
  logic [IW-1:0] res_index;

  // Search client side.
  modport master (
    output req_valid, req_key, res_ready,
    input  req_ready, res_valid, res_hit, res_index
  );

  // Controller side.
  modport slave (
    input  req_valid, req_key, res_ready,
    output req_ready, res_valid, res_hit, res_index
  );
endinterface

// File: rtl/key_table.sv
// N-entry key table: synchronous write, valid bits cleared on reset,
// combinational read by index.
module key_table import key_search_pkg::*; #(
  parameter int W  = W_DEF,
  parameter int N  = N_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          wr_vld_i,
  input  logic [IW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_key_o,
  output logic          rd_vld_o
);

  logic [W-1:0] key_q [N];
  logic         vld_q [N];

  // Valid bits: cleared by reset, updated on any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) vld_q[i] <= 1'b0;
    end else if (wr_en_i) begin
      for (int i = 0; i < N; i++)
        if (wr_addr_i == IW'(i)) vld_q[i] <= wr_vld_i;
    end
  end

  // Key storage.
  // NOTE: key bits are not reset; an entry is meaningless until its valid bit
  // is set, so resetting the array would only add reset fanout.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < N; i++)
        if (wr_addr_i == IW'(i)) key_q[i] <= wr_data_i;
    end
  end

  // Combinational read; out-of-range addresses read as an invalid zero entry.
  always_comb begin
    rd_key_o = '0;
    rd_vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rd_addr_i == IW'(i)) begin
        rd_key_o = key_q[i];
        rd_vld_o = vld_q[i];
      end
    end
  end

endmodule

// File: rtl/key_search_ctrl.sv
// Sequential key lookup: scans the key table one entry per clock with a single
// comparator and returns hit/miss plus the lowest matching index.
// Optional hit/miss statistics counters: define KEY_SEARCH_STATS_EN.
module key_search_ctrl import key_search_pkg::*; #(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_addr,
  input  logic [W-1:0]         wr_data,
  input  logic                 wr_vld,
  key_search_if.slave          sif
`ifdef KEY_SEARCH_STATS_EN
  ,
  output logic [STAT_W-1:0]    hit_cnt,
  output logic [STAT_W-1:0]    miss_cnt
`endif
);

  localparam int IW = $clog2(N);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [W-1:0]  key_q,   key_d;
  logic          hit_q,   hit_d;
  logic [IW-1:0] index_q, index_d;

  logic [W-1:0]  rd_key;
  logic          rd_vld;
  logic          match;
  logic          last_entry;

  key_table #(.W(W), .N(N), .IW(IW)) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .wr_vld_i  (wr_vld),
    .rd_addr_i (idx_q),
    .rd_key_o  (rd_key),
    .rd_vld_o  (rd_vld)
  );

  // The table read is combinational on the current index, so a write landing
  // on this edge is only seen by the comparison of the next cycle.
  assign match      = rd_vld && (rd_key == key_q);
  assign last_entry = (idx_q == IW'(N - 1));

  // State, index, latched key and result registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      key_q   <= '0;
      hit_q   <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      hit_q   <= hit_d;
      index_q <= index_d;
    end
  end

  // Next-state, scan index and result capture.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    hit_d   = hit_q;
    index_d = index_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sif.req_valid) begin
          key_d   = sif.req_key;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (match) begin
          hit_d   = 1'b1;
          index_d = idx_q;
          state_d = ST_DONE;
        end else if (last_entry) begin
          hit_d   = 1'b0;
          index_d = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (sif.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sif.req_ready = (state_q == ST_IDLE);
  assign sif.res_valid = (state_q == ST_DONE);
  assign sif.res_hit   = hit_q;
  assign sif.res_index = index_q;

`ifdef KEY_SEARCH_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q;
  logic              res_fire;

  assign res_fire = (state_q == ST_DONE) && sif.res_ready;

  // Saturating hit/miss counters, bumped once per completed result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (res_fire) begin
      if (hit_q) hit_cnt_q  <= sat_inc(hit_cnt_q);
      else       miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
